toggle_event_counter: RTL

Downstream consumer of the T flip-flop output. It treats the flip-flop's `q` as a toggle-encoded event stream and synchronises it. It converts each transition into a one-cycle pulse and counts the pulses over fixed windows. Each window's count is reported through a valid/ready output register with saturation and overrun flags.

---
 rtl/toggle_event_pkg.sv | 19 +
 rtl/toggle_edge_sync.sv | 63 ++++++
 rtl/toggle_event_counter.sv | 117 +++++++++++
 3 files changed

// File: rtl/toggle_event_pkg.sv
// Shared types and constants for the toggle event counter: FSM encoding,
// legal parameter ranges and the saturating-counter ceiling helper.
package toggle_event_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    localparam int SYNC_STAGES_MIN = 0;
    localparam int SYNC_STAGES_MAX = 3;
    localparam int WINDOW_MIN      = 2;
    localparam int WINDOW_MAX      = 65535;

    function automatic logic [63:0] cnt_max(input int unsigned width);
        return (64'd1 << width) - 64'd1;
    endfunction

endpackage

// File: rtl/toggle_edge_sync.sv
// Synchronises the toggle-encoded input and turns every transition into a
// registered single-cycle pulse.
module toggle_edge_sync
    import toggle_event_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic q_in,
    output logic pulse_out
);

    logic sync_bit;

    if (SYNC_STAGES == SYNC_STAGES_MIN) begin : g_no_sync
        assign sync_bit = q_in;
    end else begin : g_sync
        logic [SYNC_STAGES-1:0] sync_q;
        logic [SYNC_STAGES-1:0] sync_d;

        always_comb begin
            sync_d = SYNC_STAGES'({sync_q, q_in});
        end

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                sync_q <= '0;
            end else begin
                sync_q <= sync_d;
            end
        end

        assign sync_bit = sync_q[SYNC_STAGES-1];
    end

    // samp_q is the settled level; prev_q is its previous value, so the
    // XOR marks exactly one cycle per transition.
    logic samp_q, samp_d;
    logic prev_q, prev_d;
    logic pulse_q, pulse_d;

    always_comb begin
        samp_d  = sync_bit;
        prev_d  = samp_q;
        pulse_d = samp_q ^ prev_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            samp_q  <= 1'b0;
            prev_q  <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            samp_q  <= samp_d;
            prev_q  <= prev_d;
            pulse_q <= pulse_d;
        end
    end

    assign pulse_out = pulse_q;

endmodule

// File: rtl/toggle_event_counter.sv
// Counts toggle events over fixed windows and hands each window's count to a
// valid/ready output register, flagging saturation and dropped reports.
module toggle_event_counter
    import toggle_event_pkg::*;
#(
    parameter int CNT_W       = 8,
    parameter int WINDOW      = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             q_in,
    output logic             pulse_out,
    output logic [CNT_W-1:0] out_data,
    output logic             out_sat,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             overrun
);

    localparam int               WIN_W    = $clog2(WINDOW_MAX + 1);
    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW - 1);
    localparam logic [CNT_W-1:0] EV_MAX   = CNT_W'(cnt_max(CNT_W));

    toggle_edge_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_edge (
        .clk      (clk),
        .rst      (rst),
        .q_in     (q_in),
        .pulse_out(pulse_out)
    );

    state_e           state_q, state_d;
    logic [WIN_W-1:0] win_q, win_d;
    logic [CNT_W-1:0] ev_q, ev_d;
    logic             sat_q, sat_d;
    logic [CNT_W-1:0] data_q, data_d;
    logic             osat_q, osat_d;
    logic             valid_q, valid_d;
    logic             overrun_q, overrun_d;

    logic             at_max;
    logic [CNT_W-1:0] ev_next;
    logic             sat_next;
    logic             capture;
    logic             xfer;

    // ev_next/sat_next include a pulse landing in the current cycle, so the
    // capture cycle reports it too.
    assign at_max   = (ev_q == EV_MAX);
    assign ev_next  = (pulse_out && !at_max) ? ev_q + CNT_W'(1) : ev_q;
    assign sat_next = sat_q | (pulse_out & at_max);
    assign capture  = (state_q == ST_RUN) && (win_q == WIN_LAST);
    assign xfer     = valid_q && out_ready;

    always_comb begin
        state_d   = en ? ST_RUN : ST_IDLE;
        win_d     = '0;
        ev_d      = '0;
        sat_d     = 1'b0;
        data_d    = data_q;
        osat_d    = osat_q;
        valid_d   = valid_q;
        overrun_d = overrun_q;

        if (state_q == ST_RUN && !capture) begin
            win_d = win_q + WIN_W'(1);
            ev_d  = ev_next;
            sat_d = sat_next;
        end

        if (xfer) begin
            valid_d = 1'b0;
        end

        // A pending, unaccepted report wins; the new one is dropped.
        if (capture) begin
            if (!valid_q || xfer) begin
                data_d  = ev_next;
                osat_d  = sat_next;
                valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            win_q     <= '0;
            ev_q      <= '0;
            sat_q     <= 1'b0;
            data_q    <= '0;
            osat_q    <= 1'b0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            win_q     <= win_d;
            ev_q      <= ev_d;
            sat_q     <= sat_d;
            data_q    <= data_d;
            osat_q    <= osat_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
        end
    end

    assign out_data  = data_q;
    assign out_sat   = osat_q;
    assign out_valid = valid_q;
    assign overrun   = overrun_q;

endmodule
